// File: rtl/lenet_sequencer.sv
// LeNet inference sequencer: accepts a go pulse, steps the layer engine through
// each layer with start/done handshakes, then reduces streamed class scores to an argmax.
module lenet_sequencer #(
    parameter int NUM_LAYERS  = 7,
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 16,
    parameter int TIMEOUT     = 65535
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               lenet_go,
    output logic               lenet_ready,
    output logic               layer_start,
    output logic [2:0]         layer_sel,
    input  logic               layer_done,
    input  logic               score_valid,
    input  logic [SCORE_W-1:0] score_in,
    output logic               result_valid,
    output logic [3:0]         class_out,
    output logic               err,
    output logic [31:0]        cycle_count
);

    localparam int              TW         = $clog2(TIMEOUT + 1);
    localparam logic [2:0]      LAST_LAYER = 3'(NUM_LAYERS - 1);
    localparam logic [3:0]      LAST_CLASS = 4'(NUM_CLASSES - 1);
    localparam logic [TW-1:0]   TO_LAST    = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_ARGMAX
    } state_t;

    state_t                     state, state_next;
    logic [TW-1:0]              wait_cnt;
    logic [3:0]                 score_idx;
    logic [3:0]                 arg_max;
    logic signed [SCORE_W-1:0]  max_score;

    logic go_accept;
    logic layer_adv;
    logic timeout_hit;
    logic score_take;
    logic last_score;
    logic score_better;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // NOTE: every signal is given a default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next  = state;
        go_accept   = 1'b0;
        layer_adv   = 1'b0;
        timeout_hit = 1'b0;
        score_take  = 1'b0;
        last_score  = 1'b0;
        case (state)
            S_IDLE: begin
                if (lenet_go) begin
                    go_accept  = 1'b1;
                    state_next = S_START;
                end
            end
            S_START: state_next = S_WAIT;
            S_WAIT: begin
                if (layer_done) begin
                    if (layer_sel < LAST_LAYER) begin
                        layer_adv  = 1'b1;
                        state_next = S_START;
                    end else begin
                        state_next = S_ARGMAX;
                    end
                end else if (wait_cnt == TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            S_ARGMAX: begin
                if (score_valid) begin
                    score_take = 1'b1;
                    if (score_idx == LAST_CLASS) begin
                        last_score = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Strictly greater keeps the lower index on ties; index 0 always seeds the max.
    assign score_better = (score_idx == 4'd0) || ($signed(score_in) > max_score);

    assign lenet_ready = (state == S_IDLE);
    assign layer_start = (state == S_START);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            layer_sel    <= '0;
            err          <= 1'b0;
            score_idx    <= '0;
            max_score    <= '0;
            arg_max      <= '0;
            class_out    <= '0;
            result_valid <= 1'b0;
            cycle_count  <= '0;
            wait_cnt     <= '0;
        end else begin
            result_valid <= last_score;

            if (go_accept) begin
                layer_sel   <= '0;
                err         <= 1'b0;
                score_idx   <= '0;
                max_score   <= '0;
                arg_max     <= '0;
                cycle_count <= '0;
            end else if (state != S_IDLE && cycle_count != '1) begin
                cycle_count <= cycle_count + 32'd1;
            end

            if (state == S_START)     wait_cnt <= '0;
            else if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;

            if (layer_adv)   layer_sel <= layer_sel + 3'd1;
            if (timeout_hit) err       <= 1'b1;

            if (score_take) begin
                if (score_better) begin
                    max_score <= $signed(score_in);
                    arg_max   <= score_idx;
                end
                if (!last_score) score_idx <= score_idx + 4'd1;
            end

            // The final score takes part in the compare on the same edge it is written out.
            if (last_score) class_out <= score_better ? score_idx : arg_max;
        end
    end

endmodule

// File: doc/lenet_sequencer.md
# lenet_sequencer

Inference sequencer on the responder side of the `lenet_go` / `lenet_ready` handshake. It accepts the one-cycle `lenet_go` pulse and steps the LeNet compute engine through its seven layers with per-layer start/done handshakes. It then reduces the ten streamed class scores to an argmax result and re-asserts `lenet_ready`. It sits between the go-pulse controller and the shared layer datapath.

## Interface
- `NUM_LAYERS`, default 7: layers run in order, indices 0..NUM_LAYERS-1 (conv1, pool1, conv2, pool2, fc1, fc2, fc3).
- `NUM_CLASSES`, default 10: scores consumed after the last layer.
- `SCORE_W`, default 16: width of the signed two's-complement score.
- `TIMEOUT`, default 65535: maximum cycles spent waiting for a single `layer_done`.
- `clk  in  1`: the single clock, rising edge.
- `rst_n  in  1`: synchronous reset, active-low.
- `lenet_go  in  1`: one-cycle start request.
- `lenet_ready  out  1`: high when idle and able to accept `lenet_go`.
- `layer_start  out  1`: one-cycle pulse that launches the layer selected by `layer_sel`.
- `layer_sel  out  3`: index of the current layer, held stable from `layer_start` until `layer_done` is accepted.
- `layer_done  in  1`: the engine has finished the current layer.
- `score_valid  in  1`: `score_in` is valid this cycle.
- `score_in  in  SCORE_W`: class score, signed.
- `result_valid  out  1`: one-cycle pulse; `class_out` has just been updated.
- `class_out  out  4`: argmax class index, held until the next successful inference.
- `err  out  1`: sticky timeout flag.
- `cycle_count  out  32`: cycles of the last inference, from go to result, saturating at 2^32-1.

## Operation
- States: IDLE, START, WAIT, ARGMAX.
- **IDLE**
  - `lenet_ready`=1.
  - `lenet_go`=1 → START. The same edge clears `layer_sel`, `err`, the score index, max and argmax registers, and the cycle counter.
- **START**
  - `layer_start`=1 for exactly this cycle → WAIT.
  - The timeout counter clears.
- **WAIT**
  - On `layer_done`=1: if `layer_sel` < NUM_LAYERS-1, increment `layer_sel` and go to START; otherwise go to ARGMAX.
  - The timeout counter increments each cycle. When it reaches TIMEOUT with `layer_done`=0: set `err`=1, go to IDLE, no `result_valid`, `class_out` unchanged.
- **ARGMAX**
  - Each `score_valid` cycle consumes one score with index k, where k runs 0..NUM_CLASSES-1.
  - k=0 loads the max unconditionally.
  - For later k, the max and argmax update only on a strictly greater signed score, so ties keep the lower index.
  - On the cycle the score with k=NUM_CLASSES-1 is accepted, go to IDLE.
  - The same edge writes `class_out` (including that final score in the compare), pulses `result_valid`, and freezes `cycle_count`.
- Ignored inputs:
  - `lenet_go` outside IDLE.
  - `layer_done` outside WAIT, including in START.
  - `score_valid` outside ARGMAX.
- Arithmetic:
  - The score compare is signed, SCORE_W wide.
  - The score index and `layer_sel` never wrap; their terminal values force the state change.
  - `cycle_count` saturates and does not wrap.
- Outputs are registered; there are no combinational paths from input to output.

## Timing
- Reset values:
  - `lenet_ready`=1.
  - `layer_start`=0, `layer_sel`=0.
  - `result_valid`=0, `class_out`=0.
  - `err`=0, `cycle_count`=0.
  - State = IDLE.
- Reset asserted mid-inference returns to IDLE on the next edge; the engine sees no further `layer_start`.
- `lenet_go` sampled at edge t:
  - `lenet_ready`=0 from t+1.
  - `layer_start`=1 and `layer_sel`=0 during cycle t+1.
- `layer_done` sampled in WAIT at edge u:
  - For a non-last layer, the next `layer_start` is high during cycle u+1 with the incremented `layer_sel`.
  - For the last layer, ARGMAX starts in cycle u+1.
- The minimum layer turnaround is 2 cycles (START plus one WAIT cycle).
- Last score accepted at edge v:
  - `result_valid`=1 and the new `class_out` during cycle v+1.
  - `lenet_ready`=1 from v+1.
- Back-to-back: `lenet_go` is accepted in the first IDLE cycle, v+1.
- `cycle_count` counts edges from the cycle after go to the result edge inclusive.
  - With zero-wait layers (done in the first WAIT cycle) and scores on consecutive cycles: cycle_count = 2·NUM_LAYERS + NUM_CLASSES = 24 for the defaults.
- `lenet_ready` deasserts for at least NUM_LAYERS·2 + NUM_CLASSES cycles per inference, so an edge-tracking controller always observes the low phase.

## Test plan
- **Reset value check:** hold `rst_n`=0 for 3 cycles → all outputs at their reset values, `lenet_ready`=1. Then issue a go with zero-wait layers and scores 0..9 = {5,-3,7,7,2,0,-8,1,6,4} → `class_out`=2 (tie on 7 keeps the lower index), one `result_valid` pulse, `cycle_count`=24.
- **Layer sequencing:** `layer_done` delayed 5 cycles on every layer → `layer_start` pulses exactly 7 times, `layer_sel` runs 0..6, `lenet_ready` stays 0 throughout.
- **Negative scores:** all scores negative, {-100,-2,-50,…} with the maximum -2 at index 1 → `class_out`=1. Score -32768 at index 0 and all others -32768 → `class_out`=0.
- **Timeout:** TIMEOUT=16, `layer_done` never asserted on layer 3 → `err`=1 17 cycles after layer 3's start, `lenet_ready`=1, no `result_valid`, `class_out` keeps its previous value. The next go clears `err`.
- **Ignored inputs:** `lenet_go` pulses during WAIT, `layer_done` during START, and `score_valid` during WAIT → no effect on sequence or result.
- **Reset and back-to-back:** `rst_n` dropped in ARGMAX after 4 scores → IDLE on the next edge, `result_valid` never pulses. Two inferences back-to-back with go at v+1 → both results are correct.
